// File: rtl/serial_adder.sv
// Bit-serial adder/subtractor: one full-adder cell and a carry flop process
// WIDTH-bit operands LSB first, with a start/busy/done handshake.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_ps;
  logic [WIDTH-1:0] r_sum;
  logic [CW-1:0]    r_cnt;
  logic             r_c;
  logic             r_busy;
  logic             r_done;
  logic             r_cout;
  logic             r_ovf;

  logic             w_s;
  logic             w_cn;
  logic [WIDTH-1:0] w_psNext;

  assign w_s      = r_a[0] ^ r_b[0] ^ r_c;
  assign w_cn     = (r_a[0] & r_b[0]) | (r_a[0] & r_c) | (r_b[0] & r_c);
  assign w_psNext = {w_s, r_ps[WIDTH-1:1]};

  // Subtraction is A + ~B + 1, so the operand inversion and the forced carry
  // are folded into the capture and the datapath never knows the mode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_ps    <= '0;
      r_sum   <= '0;
      r_cnt   <= '0;
      r_c     <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_a     <= a;
            r_b     <= sub ? ~b : b;
            r_c     <= sub ? 1'b1 : cin;
            r_cnt   <= '0;
            r_ps    <= '0;
            r_busy  <= 1'b1;
            r_state <= RUN;
          end
        end
        RUN: begin
          r_a   <= r_a >> 1;
          r_b   <= r_b >> 1;
          r_ps  <= w_psNext;
          r_c   <= w_cn;
          r_cnt <= r_cnt + CW'(1);
          // Last bit: r_c is still the carry into the MSB here.
          if (r_cnt == LAST) begin
            r_sum   <= w_psNext;
            r_cout  <= w_cn;
            r_ovf   <= r_c ^ w_cn;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign sum  = r_sum;
  assign cout = r_cout;
  assign ovf  = r_ovf;

endmodule

// File: tb/tb_serial_adder.sv
// Directed and table-driven checks for serial_adder at WIDTH=8, plus
// exhaustive WIDTH=2 and randomised WIDTH=16 runs against a reference model.
module tb_serial_adder;

  logic clk = 1'b0;
  logic rst_n = 1'b1;

  logic       start = 1'b0;
  logic [7:0] a = '0;
  logic [7:0] b = '0;
  logic       cin = 1'b0;
  logic       sub = 1'b0;
  logic       busy, done, cout, ovf;
  logic [7:0] sum;

  logic       start2 = 1'b0;
  logic [1:0] a2 = '0;
  logic [1:0] b2 = '0;
  logic       cin2 = 1'b0;
  logic       sub2 = 1'b0;
  logic       busy2, done2, cout2, ovf2;
  logic [1:0] sum2;

  logic        start16 = 1'b0;
  logic [15:0] a16 = '0;
  logic [15:0] b16 = '0;
  logic        cin16 = 1'b0;
  logic        sub16 = 1'b0;
  logic        busy16, done16, cout16, ovf16;
  logic [15:0] sum16;

  int checks = 0;
  int passes = 0;
  logic [7:0] lastSum = '0;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic       sub;
    logic [7:0] sum;
    logic       cout;
    logic       ovf;
  } vec_t;

  vec_t vecs[12];

  serial_adder #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .cin(cin), .sub(sub),
    .busy(busy), .done(done), .sum(sum), .cout(cout), .ovf(ovf)
  );

  serial_adder #(.WIDTH(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .a(a2), .b(b2), .cin(cin2), .sub(sub2),
    .busy(busy2), .done(done2), .sum(sum2), .cout(cout2), .ovf(ovf2)
  );

  serial_adder #(.WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .start(start16), .a(a16), .b(b16), .cin(cin16), .sub(sub16),
    .busy(busy16), .done(done16), .sum(sum16), .cout(cout16), .ovf(ovf16)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Returns {sum[63:0], cout, ovf} for a w-bit add or subtract.
  function automatic logic [65:0] refModel(input int w, input logic [63:0] av, input logic [63:0] bv,
                                           input logic c, input logic s);
    logic [63:0] mask, bb, sm;
    logic [64:0] full;
    logic        co, ov;
    mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    bb   = (s ? ~bv : bv) & mask;
    full = {1'b0, av & mask} + {1'b0, bb} + 65'(s ? 1'b1 : c);
    sm   = full[63:0] & mask;
    co   = full[w];
    ov   = (av[w-1] == bb[w-1]) && (sm[w-1] != av[w-1]);
    return {sm, co, ov};
  endfunction

  task automatic applyStimulus(input string tag, input logic [7:0] av, input logic [7:0] bv,
                               input logic c, input logic s, input logic [7:0] expSum,
                               input logic expCout, input logic expOvf);
    int cyc;
    int busyCnt;
    logic stable;
    @(negedge clk);
    a = av; b = bv; cin = c; sub = s; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom); sub = 1'($urandom);
    cyc = 0; busyCnt = 0; stable = 1'b1;
    while (!done && cyc < 20) begin
      if (busy) busyCnt++;
      if (sum !== lastSum) stable = 1'b0;
      @(negedge clk);
      cyc++;
    end
    checkOutput({tag, " latency"}, 64'(cyc), 64'd8);
    checkOutput({tag, " busy cycles"}, 64'(busyCnt), 64'd8);
    checkOutput({tag, " sum held"}, 64'(stable), 64'd1);
    checkOutput({tag, " busy at done"}, 64'(busy), 64'd0);
    checkOutput({tag, " sum"}, 64'(sum), 64'(expSum));
    checkOutput({tag, " cout"}, 64'(cout), 64'(expCout));
    checkOutput({tag, " ovf"}, 64'(ovf), 64'(expOvf));
    @(negedge clk);
    checkOutput({tag, " done width"}, 64'(done), 64'd0);
    lastSum = expSum;
  endtask

  task automatic runSmall(input logic [1:0] av, input logic [1:0] bv, input logic c, input logic s);
    int cyc;
    logic [65:0] e;
    @(negedge clk);
    a2 = av; b2 = bv; cin2 = c; sub2 = s; start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    cyc = 0;
    while (!done2 && cyc < 10) begin
      @(negedge clk);
      cyc++;
    end
    e = refModel(2, 64'(av), 64'(bv), c, s);
    checkOutput($sformatf("w2 a=%0d b=%0d cin=%0d sub=%0d", av, bv, c, s),
                {52'd0, 8'(cyc), cout2, ovf2, sum2}, {52'd0, 8'd2, e[1], e[0], e[3:2]});
  endtask

  task automatic runWide(input logic [15:0] av, input logic [15:0] bv, input logic c, input logic s);
    int cyc;
    logic [65:0] e;
    @(negedge clk);
    a16 = av; b16 = bv; cin16 = c; sub16 = s; start16 = 1'b1;
    @(negedge clk);
    start16 = 1'b0;
    cyc = 0;
    while (!done16 && cyc < 24) begin
      @(negedge clk);
      cyc++;
    end
    e = refModel(16, 64'(av), 64'(bv), c, s);
    checkOutput($sformatf("w16 a=%0h b=%0h cin=%0d sub=%0d", av, bv, c, s),
                {38'd0, 8'(cyc), cout16, ovf16, sum16}, {38'd0, 8'd16, e[1], e[0], e[17:2]});
  endtask

  initial begin
    int cyc;
    int n;
    int actv;
    int t[3];

    vecs[0]  = '{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[1]  = '{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1};
    vecs[2]  = '{8'h05, 8'h07, 1'b1, 1'b1, 8'hFE, 1'b0, 1'b0};
    vecs[3]  = '{8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1};
    vecs[4]  = '{8'h00, 8'h00, 1'b1, 1'b0, 8'h01, 1'b0, 1'b0};
    vecs[5]  = '{8'h12, 8'h34, 1'b0, 1'b0, 8'h46, 1'b0, 1'b0};
    vecs[6]  = '{8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b0};
    vecs[7]  = '{8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1};
    vecs[8]  = '{8'h10, 8'h10, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0};
    vecs[9]  = '{8'h00, 8'h01, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0};
    vecs[10] = '{8'h7F, 8'hFF, 1'b0, 1'b1, 8'h80, 1'b0, 1'b1};
    vecs[11] = '{8'hC8, 8'h64, 1'b0, 1'b0, 8'h2C, 1'b1, 1'b0};

    // Asynchronous reset before any clock edge
    #3 rst_n = 1'b0;
    #1 checkOutput("reset outputs", {51'd0, busy, done, cout, ovf, sum}, 64'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    actv = 0;
    repeat (5) begin
      @(negedge clk);
      if (busy || done) actv++;
    end
    checkOutput("idle after reset", 64'(actv), 64'd0);

    for (int i = 0; i < 12; i++)
      applyStimulus($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub,
                    vecs[i].sum, vecs[i].cout, vecs[i].ovf);

    // start pulses while busy must be ignored
    @(negedge clk);
    a = 8'h33; b = 8'h11; cin = 1'b0; sub = 1'b0; start = 1'b1;
    @(negedge clk);
    cyc = 0;
    while (!done && cyc < 20) begin
      start = (cyc == 2 || cyc == 5);
      if (start) begin a = 8'hFF; b = 8'h77; sub = 1'b1; end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    checkOutput("ignored start latency", 64'(cyc), 64'd8);
    checkOutput("ignored start result", {55'd0, cout, ovf, sum}, {55'd0, 1'b0, 1'b0, 8'h44});
    actv = 0;
    repeat (12) begin
      @(negedge clk);
      if (done || busy) actv++;
    end
    checkOutput("ignored start no extra op", 64'(actv), 64'd0);

    // start held high: one op per 9 cycles
    a = 8'h01; b = 8'h02; cin = 1'b0; sub = 1'b0; start = 1'b1;
    cyc = 0; n = 0;
    while (n < 3 && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (done) begin t[n] = cyc; n++; end
    end
    start = 1'b0;
    checkOutput("b2b done count", 64'(n), 64'd3);
    checkOutput("b2b spacing 1", 64'(t[1] - t[0]), 64'd9);
    checkOutput("b2b spacing 2", 64'(t[2] - t[1]), 64'd9);
    checkOutput("b2b sum", 64'(sum), 64'h03);

    // Reset during the third RUN cycle
    @(negedge clk);
    a = 8'h10; b = 8'h20; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 checkOutput("mid-op reset outputs", {51'd0, busy, done, cout, ovf, sum}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    actv = 0;
    repeat (15) begin
      @(negedge clk);
      if (done || busy) actv++;
    end
    checkOutput("mid-op reset no done", 64'(actv), 64'd0);
    lastSum = 8'h00;
    applyStimulus("after reset", 8'h10, 8'h20, 1'b0, 1'b0, 8'h30, 1'b0, 1'b0);

    for (int i = 0; i < 64; i++)
      runSmall(2'(i >> 4), 2'(i >> 2), i[1], i[0]);

    for (int i = 0; i < 500; i++)
      runWide(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
